// File: rtl/keysched_pkg.sv
// Shared types and constants for the AES-128 key-schedule controller.
// Used by key_sched_ctrl and its testbench.
package keysched_pkg;

  localparam int KEY_W = 128;
  localparam int WORD_W = 32;
  localparam int NUM_KEYS = 11;

  localparam logic [3:0] NUM_STEPS = 4'd10;
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gFunction.sv
// AES key-expansion g function: RotWord, SubWord, Rcon XOR.
// Rcon ascends with i_Round forward and descends in inverse mode.
module gFunction (
  input  logic [31:0] i_Word,
  input  logic [3:0]  i_Round,
  input  logic        i_fEncrypt,
  output logic [31:0] o_Word
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [31:0] rot;
  logic [31:0] sub;
  logic [3:0]  ridx;

  assign rot = {i_Word[23:0], i_Word[31:24]};

  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]), sbox(rot[7:0])};

  // inverse schedule walks the round constants backward
  assign ridx = i_fEncrypt ? i_Round : (4'd9 - i_Round);

  assign o_Word = sub ^ {rcon(ridx), 24'h0};

endmodule

// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key schedule, forward or inverse, one key per cycle.
// Define KEYSCHED_CACHE_EN to add an 11-entry round-key cache with read port.
module key_sched_ctrl
  import keysched_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_fEncrypt,
  input  logic [KEY_W-1:0] i_Key,
  input  logic             i_Stall,
  output logic             o_Busy,
  output logic             o_RoundKeyValid,
  output logic [KEY_W-1:0] o_RoundKey,
  output logic [3:0]       o_Round,
  output logic             o_Done
`ifdef KEYSCHED_CACHE_EN
  ,
  input  logic [3:0]       i_RdIdx,
  output logic [KEY_W-1:0] o_RdKey,
  output logic             o_CacheValid
`endif
);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       round_q, round_d;
  logic             enc_q, enc_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] g_in, g_out;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] v0, v1, v2, v3;
  logic [KEY_W-1:0] next_key;
  logic        accept;

  assign {w0, w1, w2, w3} = key_q;

  assign g_in = enc_q ? w3 : (w3 ^ w2);

  gFunction u_gfunc (
    .i_Word     (g_in),
    .i_Round    (step_q),
    .i_fEncrypt (enc_q),
    .o_Word     (g_out)
  );

  assign f0 = w0 ^ g_out;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  // inverse undoes the chain from the top word down
  assign v3 = w3 ^ w2;
  assign v2 = w2 ^ w1;
  assign v1 = w1 ^ w0;
  assign v0 = w0 ^ g_out;

  assign next_key = enc_q ? {f0, f1, f2, f3}
                          : {v0, v1, v2, v3};

  assign accept = (state_q == RUN) && !i_Stall;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    step_d  = step_q;
    round_d = round_q;
    enc_d   = enc_q;
    unique case (state_q)
      IDLE: begin
        if (i_Start) begin
          key_d   = i_Key;
          enc_d   = i_fEncrypt;
          step_d  = 4'd0;
          round_d = i_fEncrypt ? 4'd0 : LAST_IDX;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!i_Stall) begin
          if (step_q == NUM_STEPS) begin
            state_d = DONE;
          end else begin
            key_d   = next_key;
            step_d  = step_q + 4'd1;
            round_d = enc_q ? round_q + 4'd1
                            : round_q - 4'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      step_q  <= '0;
      round_q <= '0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      step_q  <= step_d;
      round_q <= round_d;
      enc_q   <= enc_d;
    end
  end

  assign o_Busy          = (state_q == RUN);
  assign o_RoundKeyValid = (state_q == RUN);
  assign o_RoundKey      = key_q;
  assign o_Round         = round_q;
  assign o_Done          = (state_q == DONE);

`ifdef KEYSCHED_CACHE_EN
  logic [KEY_W-1:0] bank_q [NUM_KEYS];
  logic             cv_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        bank_q[i] <= '0;
      end
      cv_q <= 1'b0;
    end else begin
      if (accept) begin
        bank_q[round_q] <= key_q;
      end
      if (state_q == IDLE && i_Start) begin
        cv_q <= 1'b0;
      end else if (state_q == DONE) begin
        cv_q <= 1'b1;
      end
    end
  end

  assign o_RdKey = (i_RdIdx <= LAST_IDX) ? bank_q[i_RdIdx] : '0;
  assign o_CacheValid = cv_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl using FIPS-197 Appendix A keys.
// Driver pushes expected beats; a negedge monitor pops and compares.
module tb_key_sched_ctrl;

  logic         i_Clk = 1'b0;
  logic         i_Rst_n;
  logic         i_Start;
  logic         i_fEncrypt;
  logic [127:0] i_Key;
  logic         i_Stall;
  logic         o_Busy;
  logic         o_RoundKeyValid;
  logic [127:0] o_RoundKey;
  logic [3:0]   o_Round;
  logic         o_Done;
`ifdef KEYSCHED_CACHE_EN
  logic [3:0]   i_RdIdx;
  logic [127:0] o_RdKey;
  logic         o_CacheValid;
`endif

  key_sched_ctrl dut (
    .i_Clk           (i_Clk),
    .i_Rst_n         (i_Rst_n),
    .i_Start         (i_Start),
    .i_fEncrypt      (i_fEncrypt),
    .i_Key           (i_Key),
    .i_Stall         (i_Stall),
    .o_Busy          (o_Busy),
    .o_RoundKeyValid (o_RoundKeyValid),
    .o_RoundKey      (o_RoundKey),
    .o_Round         (o_Round),
    .o_Done          (o_Done)
`ifdef KEYSCHED_CACHE_EN
    ,
    .i_RdIdx         (i_RdIdx),
    .o_RdKey         (o_RdKey),
    .o_CacheValid    (o_CacheValid)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  int errors = 0;
  int checks = 0;
  int beats = 0;

  logic [127:0] fips [11];
  logic [127:0] exp_k [$];
  logic [3:0]   exp_r [$];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge i_Clk) begin
    if (i_Rst_n === 1'b1 && o_RoundKeyValid === 1'b1) begin
      if (exp_k.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got round %0d expected none",
                 o_Round);
      end else begin
        chk("beat_round", 128'(o_Round), 128'(exp_r[0]));
        chk("beat_key", o_RoundKey, exp_k[0]);
        if (!i_Stall) begin
          void'(exp_k.pop_front());
          void'(exp_r.pop_front());
          beats++;
        end
      end
    end
  end

  task automatic push_seq(input logic enc);
    for (int i = 0; i < 11; i++) begin
      if (enc) begin
        exp_k.push_back(fips[i]);
        exp_r.push_back(4'(i));
      end else begin
        exp_k.push_back(fips[10-i]);
        exp_r.push_back(4'(10-i));
      end
    end
  endtask

  // stall_rd/s2_rd/rst_rd = 15 disables that disturbance
  task automatic run(input logic [127:0] key,
                     input logic enc,
                     input logic [3:0] stall_rd,
                     input logic [3:0] s2_rd,
                     input logic [3:0] rst_rd,
                     input int exp_done);
    int n;
    int scnt;
    int b0;
    bit did;
    bit s2_on;
    bit got;
    push_seq(enc);
    b0 = beats;
    i_Start = 1'b1;
    i_fEncrypt = enc;
    i_Key = key;
    @(posedge i_Clk);
    #1;
    i_Start = 1'b0;
    i_Key = '0;
    n = 0;
    scnt = 0;
    did = 0;
    s2_on = 0;
    got = 0;
    while (n < 40 && !got) begin
      if (s2_on) begin
        i_Start = 1'b0;
        s2_on = 0;
      end
      if (scnt > 0) begin
        scnt--;
        if (scnt == 0) i_Stall = 1'b0;
      end else if (!did && o_RoundKeyValid &&
                   o_Round == stall_rd) begin
        i_Stall = 1'b1;
        scnt = 3;
        did = 1;
      end
      if (o_RoundKeyValid && o_Round == s2_rd && !s2_on) begin
        i_Start = 1'b1;
        i_fEncrypt = ~enc;
        i_Key = 128'h00112233445566778899aabbccddeeff;
        s2_on = 1;
        s2_rd = 4'hf;
      end
      if (o_RoundKeyValid && o_Round == rst_rd) begin
        i_Rst_n = 1'b0;
        #1;
        chk("async_reset_outs",
            {o_Busy, o_RoundKeyValid, o_Round, o_Done, o_RoundKey},
            '0);
        exp_k.delete();
        exp_r.delete();
        @(posedge i_Clk);
        #1;
        chk("reset_no_done", 128'(o_Done), 128'd0);
        i_Rst_n = 1'b1;
        return;
      end
      @(posedge i_Clk);
      #1;
      n++;
      if (o_Done) got = 1;
    end
    i_Start = 1'b0;
    i_Stall = 1'b0;
    chk("done_seen", 128'(got), 128'd1);
    chk("done_cycle", 128'(n), 128'(exp_done));
    chk("beat_count", 128'(beats - b0), 128'd11);
    chk("sb_empty", 128'(exp_k.size()), 128'd0);
    @(posedge i_Clk);
    #1;
    chk("done_pulse_one", 128'(o_Done), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    i_Rst_n = 1'b0;
    i_Start = 1'b0;
    i_fEncrypt = 1'b1;
    i_Key = '0;
    i_Stall = 1'b0;
`ifdef KEYSCHED_CACHE_EN
    i_RdIdx = 4'd0;
`endif
    #2;
    chk("reset_outs",
        {o_Busy, o_RoundKeyValid, o_Round, o_Done, o_RoundKey}, '0);
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;
    i_Stall = 1'b1;
    @(posedge i_Clk);
    #1;
    chk("idle_stall_no_busy", 128'(o_Busy), 128'd0);
    i_Stall = 1'b0;

    run(fips[0], 1'b1, 4'hf, 4'hf, 4'hf, 11);
`ifdef KEYSCHED_CACHE_EN
    chk("cache_valid", 128'(o_CacheValid), 128'd1);
    i_RdIdx = 4'd10;
    #1;
    chk("cache_rd10", o_RdKey, fips[10]);
    i_RdIdx = 4'd12;
    #1;
    chk("cache_rd12", o_RdKey, '0);
`endif
    run(fips[10], 1'b0, 4'hf, 4'hf, 4'hf, 11);
    run(fips[0], 1'b1, 4'd4, 4'hf, 4'hf, 14);
    run(fips[0], 1'b1, 4'hf, 4'd5, 4'hf, 11);
    run(fips[10], 1'b0, 4'hf, 4'd5, 4'hf, 11);
    run(fips[0], 1'b1, 4'hf, 4'hf, 4'd6, 0);
    run(fips[0], 1'b1, 4'hf, 4'hf, 4'hf, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
